pair_dist_engine: RTL and testbench

PAIR_DIST_ENGINE -- requirements
Module: pair_dist_engine

---
 rtl/pair_dist_pkg.sv | 16 +
 rtl/pd_absdiff.sv | 20 ++
 rtl/pair_dist_engine.sv | 164 ++++++++++++++++
 tb/tb_pair_dist_engine.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/pair_dist_pkg.sv
// Shared types and default sizing for the pairwise-distance engine.
package pair_dist_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    CMP  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam int DEF_W  = 16;
  localparam int DEF_N  = 32;
  localparam int DEF_AW = 8;
  localparam int IDX_W  = 8;

endpackage

// File: rtl/pd_absdiff.sv
// Combinational signed absolute difference; result is the W-bit unsigned magnitude.
module pd_absdiff #(
  parameter int DATA_W = 16
) (
  input  logic signed [DATA_W-1:0] a,
  input  logic signed [DATA_W-1:0] b,
  output logic        [DATA_W-1:0] d
);

  // |x| of a (DATA_W+1)-bit difference always fits in DATA_W unsigned bits.
  function automatic logic [DATA_W-1:0] abs_mag(input logic signed [DATA_W:0] x);
    return DATA_W'(x[DATA_W] ? -x : x);
  endfunction

  logic signed [DATA_W:0] diff;

  assign diff = (DATA_W+1)'(a) - (DATA_W+1)'(b);
  assign d    = abs_mag(diff);

endmodule

// File: rtl/pair_dist_engine.sv
// Loads N signed operands from a sync-read memory, then scans all i<j pairs for min/max |op[i]-op[j]|.
// Optional macro PAIR_DIST_LOC_EN adds the pair-index registers behind min_i/min_j/max_i/max_j.
module pair_dist_engine
  import pair_dist_pkg::*;
#(
  parameter int W    = DEF_W,
  parameter int N    = DEF_N,
  parameter int AW   = DEF_AW,
  parameter int BASE = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  output logic                 done,
  output logic [AW-1:0]        rd_addr,
  input  logic signed [W-1:0]  rd_data,
  output logic [W-1:0]         min_dist,
  output logic [W-1:0]         max_dist,
  output logic [IDX_W-1:0]     min_i,
  output logic [IDX_W-1:0]     min_j,
  output logic [IDX_W-1:0]     max_i,
  output logic [IDX_W-1:0]     max_j
);

  localparam int               IW     = (N > 1) ? $clog2(N) : 1;
  localparam logic [AW-1:0]    BASE_A = AW'(BASE);
  localparam logic [8:0]       N9     = 9'(N);
  localparam logic [8:0]       NM1_9  = 9'(N - 1);
  localparam logic [IDX_W-1:0] LAST   = IDX_W'(N - 1);

  state_t                 state;
  logic [8:0]             cnt;
  logic [IDX_W-1:0]       ci;
  logic [IDX_W-1:0]       cj;
  logic                   iss;
  logic                   vld_p1;
  logic                   last_p1;
  logic [W-1:0]           dist_p1;
  logic signed [W-1:0]    op [0:(1<<IW)-1];
  logic [W-1:0]           dist_p0;
  logic                   acc;
  logic                   upd_min;
  logic                   upd_max;

  assign acc     = start && (state == IDLE || state == DONE);
  assign upd_min = vld_p1 && (dist_p1 < min_dist);
  assign upd_max = vld_p1 && (dist_p1 > max_dist);

  pd_absdiff #(.DATA_W(W)) u_absdiff (
    .a (op[IW'(ci)]),
    .b (op[IW'(cj)]),
    .d (dist_p0)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      done     <= 1'b0;
      rd_addr  <= BASE_A;
      min_dist <= '1;
      max_dist <= '0;
      cnt      <= '0;
      ci       <= '0;
      cj       <= '0;
      iss      <= 1'b0;
      vld_p1   <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state    <= LOAD;
            done     <= 1'b0;
            cnt      <= '0;
            rd_addr  <= BASE_A;
            min_dist <= '1;
            max_dist <= '0;
          end
        end
        LOAD: begin
          // cnt tracks the address issued this cycle; data lands one cycle later.
          cnt <= cnt + 9'd1;
          if (cnt < NM1_9) rd_addr <= BASE_A + AW'(cnt + 9'd1);
          else             rd_addr <= BASE_A;
          if (cnt == N9) begin
            state <= CMP;
            ci    <= '0;
            cj    <= IDX_W'(1);
            iss   <= 1'b1;
          end
        end
        CMP: begin
          if (iss) begin
            if (cj == LAST) begin
              ci <= ci + IDX_W'(1);
              cj <= ci + IDX_W'(2);
            end else begin
              cj <= cj + IDX_W'(1);
            end
            if (ci == LAST - IDX_W'(1) && cj == LAST) iss <= 1'b0;
          end
          vld_p1 <= iss;
          if (upd_min) min_dist <= dist_p1;
          if (upd_max) max_dist <= dist_p1;
          if (vld_p1 && last_p1) begin
            state <= DONE;
            done  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Stage p0 -> p1: operand capture and registered pair distance.
  always_ff @(posedge clk) begin
    if (state == LOAD && cnt != 9'd0) op[IW'(cnt - 9'd1)] <= rd_data;
    if (state == CMP && iss) begin
      dist_p1 <= dist_p0;
      last_p1 <= (ci == LAST - IDX_W'(1)) && (cj == LAST);
    end
  end

`ifdef PAIR_DIST_LOC_EN
  logic [IDX_W-1:0] i_p1;
  logic [IDX_W-1:0] j_p1;

  always_ff @(posedge clk) begin
    if (state == CMP && iss) begin
      i_p1 <= ci;
      j_p1 <= cj;
    end
  end

  // Stage p1 -> out: index tracking follows the same strict compares as the distances.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      min_i <= '0;
      min_j <= '0;
      max_i <= '0;
      max_j <= '0;
    end else if (acc) begin
      min_i <= '0;
      min_j <= '0;
      max_i <= '0;
      max_j <= '0;
    end else if (state == CMP) begin
      if (upd_min) begin
        min_i <= i_p1;
        min_j <= j_p1;
      end
      if (upd_max) begin
        max_i <= i_p1;
        max_j <= j_p1;
      end
    end
  end
`else
  assign min_i = '0;
  assign min_j = '0;
  assign max_i = '0;
  assign max_j = '0;
`endif

endmodule

// File: tb/tb_pair_dist_engine.sv
// Scoreboard bench for pair_dist_engine: directed and random runs against a pairwise reference model.
module tb_pair_dist_engine;

  localparam int W    = 16;
  localparam int N    = 32;
  localparam int AW   = 8;
  localparam int BASE = 5;
  localparam int P    = N * (N - 1) / 2;
  localparam int LAT  = N + 1 + P + 1;

  logic                clk = 1'b0;
  logic                rst_n;
  logic                start;
  logic                done;
  logic [AW-1:0]       rd_addr;
  logic signed [W-1:0] rd_data;
  logic [W-1:0]        min_dist;
  logic [W-1:0]        max_dist;
  logic [7:0]          min_i, min_j, max_i, max_j;

  logic signed [W-1:0] mem [0:(1<<AW)-1];

  pair_dist_engine #(.W(W), .N(N), .AW(AW), .BASE(BASE)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .done     (done),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .min_dist (min_dist),
    .max_dist (max_dist),
    .min_i    (min_i),
    .min_j    (min_j),
    .max_i    (max_i),
    .max_j    (max_j)
  );

  always #5 clk = ~clk;

  always @(posedge clk) rd_data <= mem[rd_addr];

  int edge_cnt = 0;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  typedef struct {
    int mn, mx, mni, mnj, mxi, mxj;
    int acc_edge;
  } exp_t;

  exp_t q[$];
  int vectors    = 0;
  int miscompares = 0;

  task automatic check(input string name, input longint act, input longint req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  // Reference: enumerate every pair in i-outer/j-inner order, first strict winner kept.
  function automatic exp_t model();
    exp_t e;
    int   v [N];
    int   d;
    for (int k = 0; k < N; k++) v[k] = int'(mem[BASE + k]);
    e.mn = (1 << W) - 1; e.mx = 0;
    e.mni = 0; e.mnj = 0; e.mxi = 0; e.mxj = 0;
    e.acc_edge = 0;
    for (int i = 0; i < N - 1; i++)
      for (int j = i + 1; j < N; j++) begin
        d = (v[i] > v[j]) ? v[i] - v[j] : v[j] - v[i];
        if (d < e.mn) begin e.mn = d; e.mni = i; e.mnj = j; end
        if (d > e.mx) begin e.mx = d; e.mxi = i; e.mxj = j; end
      end
    return e;
  endfunction

  // Monitor: compare on every rising edge of done.
  initial begin
    exp_t e;
    logic done_q;
    done_q = 1'b0;
    forever begin
      @(negedge clk);
      if (done === 1'b1 && done_q !== 1'b1) begin
        if (q.size() == 0) begin
          check("unexpected_done", 1, 0);
        end else begin
          e = q.pop_front();
          check("done_latency", edge_cnt - e.acc_edge, LAT);
          check("min_dist", min_dist, e.mn);
          check("max_dist", max_dist, e.mx);
`ifdef PAIR_DIST_LOC_EN
          check("min_i", min_i, e.mni);
          check("min_j", min_j, e.mnj);
          check("max_i", max_i, e.mxi);
          check("max_j", max_j, e.mxj);
`else
          check("min_i_zero", min_i, 0);
          check("min_j_zero", min_j, 0);
          check("max_i_zero", max_i, 0);
          check("max_j_zero", max_j, 0);
`endif
          check("rd_addr_idle", rd_addr, BASE);
        end
      end
      done_q = done;
    end
  end

  // Called on a negedge; the following posedge accepts start.
  task automatic start_run();
    exp_t e;
    e = model();
    e.acc_edge = edge_cnt + 1;
    q.push_back(e);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("done_clear_on_start", done, 0);
  endtask

  task automatic wait_done();
    int k;
    k = 0;
    while (done !== 1'b1 && k < LAT + 50) begin
      @(negedge clk);
      k++;
    end
    if (done !== 1'b1) check("done_timeout", 0, 1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_done"}, done, 0);
    check({tag, "_rd_addr"}, rd_addr, BASE);
    check({tag, "_min_dist"}, min_dist, (1 << W) - 1);
    check({tag, "_max_dist"}, max_dist, 0);
    check({tag, "_idx"}, {min_i, min_j, max_i, max_j}, 0);
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    for (int a = 0; a < (1 << AW); a++) mem[a] = '0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // All operands equal.
    for (int k = 0; k < N; k++) mem[BASE + k] = 16'sd5;
    start_run();
    wait_done();

    // Extreme operands at both ends.
    for (int k = 0; k < N; k++) mem[BASE + k] = '0;
    mem[BASE]         = -16'sd32768;
    mem[BASE + N - 1] = 16'sd32767;
    start_run();
    wait_done();

    // Arithmetic ramp with many ties; stray start pulses in LOAD and CMP are ignored.
    for (int k = 0; k < N; k++) mem[BASE + k] = W'(3 * k);
    start_run();
    repeat (10) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (200) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done();
    repeat (6) @(negedge clk);
    check("hold_min_dist", min_dist, 3);
    check("hold_max_dist", max_dist, 93);
    check("hold_done", done, 1);

    // Reset mid-CMP abandons the run; a fresh start runs in full.
    for (int k = 0; k < N; k++) mem[BASE + k] = W'($urandom);
    start_run();
    repeat (N + 200) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("async_reset");
    q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    start_run();
    wait_done();

    // Back-to-back runs, restarting in the cycle done is high.
    for (int r = 0; r < 10; r++) begin
      for (int k = 0; k < N; k++)
        mem[BASE + k] = (r % 2 == 0) ? W'($urandom_range(40, 0)) - 16'sd20 : W'($urandom);
      start_run();
      wait_done();
    end
    repeat (4) @(negedge clk);
    check("queue_drained", q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
